// File: rtl/segment_led_hex_display_driver.sv
// Time-multiplexed common-anode 7-segment hex display driver with load-captured shadow data.
// Optional leading-zero auto-blanking: define SEGMENT_LED_HEX_DISPLAY_DRIVER_LEADING_ZERO_BLANK_EN.
module segment_led_hex_display_driver #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic                  Clk,
  input  logic                  nReset,
  input  logic [4*DIGITS-1:0]   Value,
  input  logic [DIGITS-1:0]     Blank,
  input  logic [DIGITS-1:0]     DotMask,
  input  logic                  Load,
  output logic [6:0]            Segments,
  output logic                  Dot,
  output logic [DIGITS-1:0]     Anodes,
  output logic                  FrameStart
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] shadow_value;
  logic [DIGITS-1:0]   shadow_blank;
  logic [DIGITS-1:0]   shadow_dot;

  logic                slot_wrap_c;
  logic                frame_wrap_c;
  logic                guard_c;
  logic [DIGITS-1:0]   auto_blank_c;
  logic [3:0]          cur_nib_c;
  logic                cur_blank_c;
  logic                cur_dot_c;
  logic [DIGITS-1:0]   anodes_c;

  // Shared abcdefg active-low hex encoding
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b000_0001;
      4'h1:    seg = 7'b100_1111;
      4'h2:    seg = 7'b001_0010;
      4'h3:    seg = 7'b000_0110;
      4'h4:    seg = 7'b100_1100;
      4'h5:    seg = 7'b010_0100;
      4'h6:    seg = 7'b010_0000;
      4'h7:    seg = 7'b000_1111;
      4'h8:    seg = 7'b000_0000;
      4'h9:    seg = 7'b000_0100;
      4'hA:    seg = 7'b000_1000;
      4'hB:    seg = 7'b110_0000;
      4'hC:    seg = 7'b011_0001;
      4'hD:    seg = 7'b100_0010;
      4'hE:    seg = 7'b011_0000;
      default: seg = 7'b011_1000;
    endcase
    return seg;
  endfunction

  assign slot_wrap_c  = (div_cnt == CNT_MAX);
  assign frame_wrap_c = slot_wrap_c && (idx == IDX_MAX);
  assign guard_c      = (div_cnt < GUARD_END);

  // Slot divider and digit index
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (slot_wrap_c) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  // Shadow capture; scan timing is independent of Load
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      shadow_value <= '0;
      shadow_blank <= '0;
      shadow_dot   <= '0;
    end else if (Load) begin
      shadow_value <= Value;
      shadow_blank <= Blank;
      shadow_dot   <= DotMask;
    end
  end

`ifdef SEGMENT_LED_HEX_DISPLAY_DRIVER_LEADING_ZERO_BLANK_EN
  logic lz_run_c;

  // Blank zero digits from the top down to the first nonzero one; digit 0 always shown
  always_comb begin
    auto_blank_c = '0;
    lz_run_c     = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      lz_run_c        = lz_run_c & (shadow_value[4*i +: 4] == 4'h0);
      auto_blank_c[i] = lz_run_c;
    end
  end
`else
  assign auto_blank_c = '0;
`endif

  // Select the active digit's data and anode
  always_comb begin
    cur_nib_c   = '0;
    cur_blank_c = 1'b0;
    cur_dot_c   = 1'b0;
    anodes_c    = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib_c   = shadow_value[4*i +: 4];
        cur_blank_c = shadow_blank[i] | auto_blank_c[i];
        cur_dot_c   = shadow_dot[i];
        if (!guard_c) anodes_c[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      Segments   <= 7'b111_1111;
      Dot        <= 1'b1;
      Anodes     <= '1;
      FrameStart <= 1'b0;
    end else begin
      Segments   <= cur_blank_c ? 7'b111_1111 : hex_to_seg(cur_nib_c);
      Dot        <= cur_blank_c | ~cur_dot_c;
      Anodes     <= anodes_c;
      FrameStart <= frame_wrap_c;
    end
  end

endmodule

// File: doc/segment_led_hex_display_driver.md
Name: segment_led_hex_display_driver

Overview:
- Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display: hex nibbles in, active-low segment pattern and active-low digit anode out.
- Reverse direction of the segment-to-hex decoding path; both share one segment encoding.
- Captures the display value in a shadow register on a load strobe and scans digits with a programmable dwell and anti-ghosting guard.

Parameters:
- DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 50000, clock cycles per digit slot (>= GUARD_CYCLES+2).
- GUARD_CYCLES, 2, cycles at the start of each slot with all anodes off.

Ports:
- Clk  input  1  system clock, rising edge.
- nReset  input  1  asynchronous, active-low reset.
- Value  input  4*DIGITS  hex nibbles; nibble i = Value[4i+3:4i], digit 0 rightmost.
- Blank  input  DIGITS  per-digit force-blank.
- DotMask  input  DIGITS  per-digit decimal point enable.
- Load  input  1  capture Value/Blank/DotMask into the shadow registers.
- Segments  output  7  {a,b,c,d,e,f,g}, MSB = a, active-low.
- Dot  output  1  decimal point, active-low.
- Anodes  output  DIGITS  one-hot-low digit select.
- FrameStart  output  1  one-cycle pulse when the scan wraps to digit 0.

Behaviour:
- Reset (async assert, sync release):
  - DivCnt=0, Idx=0, shadow registers = 0.
  - Anodes all 1, Segments 7'b111_1111, Dot=1, FrameStart=0.
- DivCnt counts 0..REFRESH_DIV-1 and wraps.
- On wrap, Idx advances modulo DIGITS (DIGITS-1 -> 0).
- FrameStart=1 in the cycle after Idx transitions DIGITS-1 -> 0; otherwise 0.
- Outputs are registered and reflect the (DivCnt, Idx, shadow) values held before the same edge, i.e. 1-cycle latency.
- Guard: if DivCnt < GUARD_CYCLES, Anodes all 1. Segments and Dot still carry the slot's digit.
- Else Anodes[Idx]=0 and all other anodes are 1.
- Load: the shadow registers update on the edge where Load=1. The new data is visible on outputs one cycle later, mid-slot if applicable. Scan timing is unaffected.
- Load held high recaptures every cycle. Load is ignored while nReset=0.
- Segment encoding, active-low, abcdefg:
  - 0=000_0001, 1=100_1111, 2=001_0010, 3=000_0110
  - 4=100_1100, 5=010_0100, 6=010_0000, 7=000_1111
  - 8=000_0000, 9=000_0100, A=000_1000, b=110_0000
  - C=011_0001, d=100_0010, E=011_0000, F=011_1000
- Blank[Idx]=1 -> Segments=111_1111 and Dot=1. The anode is still driven, which keeps brightness duty uniform.
- Dot = ~DotMask[Idx], unless blanked.
- DIGITS=1: Idx stays 0, and FrameStart pulses once per REFRESH_DIV cycles.
- Reset mid-slot: immediate all-off outputs; the scan restarts at digit 0 with DivCnt=0.

Optional Feature:
- Macro: SEGMENT_LED_HEX_DISPLAY_DRIVER_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits from DIGITS-1 downward whose shadow nibble is 0 are blanked, up to the first nonzero nibble.
  - Digit 0 is never auto-blanked.
  - The blank set is computed combinationally from the shadow register and ORed with Blank.
  - DotMask on an auto-blanked digit is suppressed.
- Undefined: only Blank blanks; zeros are displayed.

Test Plan:
Bench settings: DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1.
1. Reset held, then released -> Anodes=4'b1111, Segments=111_1111, Dot=1. First edge after release: Anodes=1111 (guard). Next edge: Anodes=1110, Segments=000_0001.
2. Load Value=16'h3A7F, Blank=0, DotMask=0 -> over one frame, with Anodes low at 1110/1101/1011/0111, Segments read 011_1000 (F), 000_1111 (7), 000_1000 (A), 000_0110 (3). FrameStart pulses once per 16 cycles.
3. Value=16'h1234, Blank=4'b0100, DotMask=4'b0001 -> digit 2 shows 111_1111 with Anodes=1011. Digit 0 shows 100_1100 with Dot=0; all other digits have Dot=1.
4. Load pulses at DivCnt=2 of digit 1 with new Value -> Segments change on the next cycle while Anodes stay 1101. Slot and frame timing are unchanged.
5. Assert nReset at DivCnt=2, Idx=3 -> outputs go all-off asynchronously. After release, the scan restarts at digit 0, and FrameStart stays 0 until the next wrap.
6. Macro defined, Value=16'h0050 -> digits 3 and 2 blank, digit 1 = 010_0100 (5), digit 0 = 000_0001 (0). Value=16'h0000 -> only digit 0 lit, showing 0.
